// File: rtl/adsr_envelope.sv
// Monophonic ADSR envelope generator with last-note priority.
// Consumes single-cycle note_on/note_off pulses and advances the envelope
// on a free-running prescaled tick. Every output comes from a flop.
module adsr_envelope #(
  parameter int ENV_W    = 16,
  parameter int TICK_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_on,
  input  logic             note_off,
  input  logic [6:0]       note_in,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] decay_rate,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic [ENV_W-1:0] release_rate,
  output logic [ENV_W-1:0] env_out,
  output logic             gate,
  output logic [6:0]       held_note,
  output logic             env_active,
  output logic [2:0]       state_out
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ENV_W-1:0] ENV_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [ENV_W-1:0] env_nxt;
  logic             gate_nxt;
  logic [6:0]       held_nxt;
  logic [ENV_W:0]   step;

  // Rising step clamped at full scale; MSB flags that the ceiling was hit.
  // A zero rate means "jump straight to the ceiling".
  function automatic logic [ENV_W:0] sat_rise(input logic [ENV_W-1:0] level,
                                               input logic [ENV_W-1:0] rate);
    logic [ENV_W:0] sum;
    sum = {1'b0, level} + {1'b0, rate};
    if (rate == '0 || sum >= {1'b0, ENV_MAX}) return {1'b1, ENV_MAX};
    return {1'b0, sum[ENV_W-1:0]};
  endfunction

  // Falling step clamped at a floor; MSB flags that the floor was reached.
  // The compare is done one bit wider so floor + rate cannot wrap.
  function automatic logic [ENV_W:0] sat_fall(input logic [ENV_W-1:0] level,
                                               input logic [ENV_W-1:0] rate,
                                               input logic [ENV_W-1:0] floor);
    logic [ENV_W:0] limit;
    limit = {1'b0, floor} + {1'b0, rate};
    if (rate == '0 || {1'b0, level} <= limit) return {1'b1, floor};
    return {1'b0, level - rate};
  endfunction

  assign tick      = (cnt == TICK_LAST);
  assign state_out = state;

  // Free-running prescaler; note events never disturb its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // State and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      env_out    <= '0;
      gate       <= 1'b0;
      held_note  <= '0;
      env_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      env_out    <= env_nxt;
      gate       <= gate_nxt;
      held_note  <= held_nxt;
      env_active <= (state_nxt != IDLE);
    end
  end

  // Next-state and envelope arithmetic. A note event takes priority over
  // the tick, so a retrigger never also applies a step to the old state.
  always_comb begin
    state_nxt = state;
    env_nxt   = env_out;
    gate_nxt  = gate;
    held_nxt  = held_note;
    step      = '0;
    if (note_on) begin
      // Legato retrigger: level is kept, attack resumes from it.
      held_nxt  = note_in;
      gate_nxt  = 1'b1;
      state_nxt = ATTACK;
    end else if (note_off && gate && (note_in == held_note) &&
                 (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      gate_nxt  = 1'b0;
      state_nxt = RELEASE;
    end else begin
      case (state)
        ATTACK: if (tick) begin
          step    = sat_rise(env_out, attack_rate);
          env_nxt = step[ENV_W-1:0];
          if (step[ENV_W]) state_nxt = DECAY;
        end
        DECAY: if (tick) begin
          step    = sat_fall(env_out, decay_rate, sustain_level);
          env_nxt = step[ENV_W-1:0];
          if (step[ENV_W]) state_nxt = SUSTAIN;
        end
        // Sustain tracks live level edits every cycle, not just on tick.
        SUSTAIN: env_nxt = sustain_level;
        RELEASE: if (tick) begin
          step    = sat_fall(env_out, release_rate, '0);
          env_nxt = step[ENV_W-1:0];
          if (step[ENV_W]) state_nxt = IDLE;
        end
        default: begin
          env_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with TICK_DIV=4: a per-step vector table
// for the main attack/decay/sustain/release walk, then hand-written
// sequences for retrigger, same-cycle events, tick coincidence, zero rates
// and asynchronous reset.
module tb_adsr_envelope;

  localparam int ENV_W = 16;
  localparam int TDIV  = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_ATT = 3'd1, S_DEC = 3'd2,
                         S_SUS = 3'd3, S_REL = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             note_on = 1'b0, note_off = 1'b0;
  logic [6:0]       note_in = '0;
  logic [ENV_W-1:0] attack_rate = 16'h4000, decay_rate = 16'h1000;
  logic [ENV_W-1:0] sustain_level = 16'h8000, release_rate = 16'h2000;
  logic [ENV_W-1:0] env_out;
  logic             gate, env_active;
  logic [6:0]       held_note;
  logic [2:0]       state_out;

  int n_cmp = 0;
  int n_bad = 0;

  adsr_envelope #(.ENV_W(ENV_W), .TICK_DIV(TDIV)) dut (
    .clk(clk), .rst_n(rst_n), .note_on(note_on), .note_off(note_off),
    .note_in(note_in), .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .env_out(env_out), .gate(gate), .held_note(held_note),
    .env_active(env_active), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        on;
    logic        off;
    logic [6:0]  note;
    logic [15:0] sus;
    int          cyc;
    logic [15:0] env;
    logic        gate;
    logic [6:0]  held;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl[17];

  task automatic field(input string nm, input string fld,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got %0h want %0h", nm, fld, got, want);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] e_env, input logic e_gate,
                     input logic [6:0] e_held, input logic [2:0] e_st);
    field(nm, "env", 32'(env_out), 32'(e_env));
    field(nm, "gate", 32'(gate), 32'(e_gate));
    field(nm, "held", 32'(held_note), 32'(e_held));
    field(nm, "state", 32'(state_out), 32'(e_st));
    field(nm, "active", 32'(env_active), 32'(e_st != S_IDLE));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse followed by n-1 idle cycles.
  task automatic pulse(input logic on, input logic off, input logic [6:0] nt, input int n);
    note_on  = on;
    note_off = off;
    note_in  = nt;
    cycle();
    note_on  = 1'b0;
    note_off = 1'b0;
    repeat (n - 1) cycle();
  endtask

  initial begin
    // Edges counted from reset release; ticks land on edges 4, 8, 12, ...
    tbl[0]  = '{1'b0, 1'b0, 7'd0,  16'h8000, 1,  16'h0000, 1'b0, 7'd0,  S_IDLE}; // E1
    tbl[1]  = '{1'b1, 1'b0, 7'd60, 16'h8000, 1,  16'h0000, 1'b1, 7'd60, S_ATT};  // E2
    tbl[2]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 2,  16'h4000, 1'b1, 7'd60, S_ATT};  // E4
    tbl[3]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'h8000, 1'b1, 7'd60, S_ATT};  // E8
    tbl[4]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'hC000, 1'b1, 7'd60, S_ATT};  // E12
    tbl[5]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'hFFFF, 1'b1, 7'd60, S_DEC};  // E16
    tbl[6]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'hEFFF, 1'b1, 7'd60, S_DEC};  // E20
    tbl[7]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 24, 16'h8FFF, 1'b1, 7'd60, S_DEC};  // E44
    tbl[8]  = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'h8000, 1'b1, 7'd60, S_SUS};  // E48
    tbl[9]  = '{1'b0, 1'b1, 7'd62, 16'h8000, 1,  16'h8000, 1'b1, 7'd60, S_SUS};  // E49
    tbl[10] = '{1'b0, 1'b0, 7'd60, 16'h6000, 1,  16'h6000, 1'b1, 7'd60, S_SUS};  // E50
    tbl[11] = '{1'b0, 1'b0, 7'd60, 16'h8000, 2,  16'h8000, 1'b1, 7'd60, S_SUS};  // E52
    tbl[12] = '{1'b0, 1'b1, 7'd60, 16'h8000, 1,  16'h8000, 1'b0, 7'd60, S_REL};  // E53
    tbl[13] = '{1'b0, 1'b0, 7'd60, 16'h8000, 3,  16'h6000, 1'b0, 7'd60, S_REL};  // E56
    tbl[14] = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'h4000, 1'b0, 7'd60, S_REL};  // E60
    tbl[15] = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'h2000, 1'b0, 7'd60, S_REL};  // E64
    tbl[16] = '{1'b0, 1'b0, 7'd60, 16'h8000, 4,  16'h0000, 1'b0, 7'd60, S_IDLE}; // E68

    // Reset held across two edges.
    cycle();
    cycle();
    chk("reset", 16'h0000, 1'b0, 7'd0, S_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      sustain_level = tbl[i].sus;
      pulse(tbl[i].on, tbl[i].off, tbl[i].note, tbl[i].cyc);
      chk($sformatf("vec%0d", i), tbl[i].env, tbl[i].gate, tbl[i].held, tbl[i].st);
    end

    // Legato retrigger from RELEASE and same-cycle note_on/note_off.
    attack_rate  = 16'h3000;
    release_rate = 16'h1000;
    pulse(1'b1, 1'b0, 7'd64, 4);                                 // E72
    chk("att64", 16'h3000, 1'b1, 7'd64, S_ATT);
    pulse(1'b0, 1'b1, 7'd64, 1);                                 // E73
    chk("rel64", 16'h3000, 1'b0, 7'd64, S_REL);
    pulse(1'b1, 1'b0, 7'd64, 1);                                 // E74
    chk("retrig64", 16'h3000, 1'b1, 7'd64, S_ATT);
    note_on = 1'b1; note_off = 1'b1; note_in = 7'd65;
    cycle();                                                     // E75
    note_on = 1'b0; note_off = 1'b0;
    chk("on_wins", 16'h3000, 1'b1, 7'd65, S_ATT);
    cycle();                                                     // E76
    chk("legato", 16'h6000, 1'b1, 7'd65, S_ATT);
    pulse(1'b0, 1'b1, 7'd64, 1);                                 // E77
    chk("off_stale", 16'h6000, 1'b1, 7'd65, S_ATT);

    // note_on on a tick edge: the tick is not applied.
    cycle(); cycle();                                            // E79
    pulse(1'b1, 1'b0, 7'd66, 1);                                 // E80
    chk("on_tick", 16'h6000, 1'b1, 7'd66, S_ATT);
    repeat (4) cycle();                                          // E84
    chk("after_tick", 16'h9000, 1'b1, 7'd66, S_ATT);

    // Zero rates: instant jumps, no wrap.
    attack_rate = '0; decay_rate = '0; release_rate = '0;
    sustain_level = 16'h5000;
    pulse(1'b1, 1'b0, 7'd67, 4);                                 // E88
    chk("z_att", 16'hFFFF, 1'b1, 7'd67, S_DEC);
    repeat (4) cycle();                                          // E92
    chk("z_dec", 16'h5000, 1'b1, 7'd67, S_SUS);
    pulse(1'b0, 1'b1, 7'd67, 1);                                 // E93
    chk("z_off", 16'h5000, 1'b0, 7'd67, S_REL);
    repeat (3) cycle();                                          // E96
    chk("z_rel", 16'h0000, 1'b0, 7'd67, S_IDLE);

    // Asynchronous reset mid-attack, then prescaler restarts from zero.
    attack_rate = 16'h4000;
    pulse(1'b1, 1'b0, 7'd60, 4);                                 // E100
    chk("pre_rst", 16'h4000, 1'b1, 7'd60, S_ATT);
    cycle();                                                     // E101
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 16'h0000, 1'b0, 7'd0, S_IDLE);
    cycle();
    rst_n = 1'b1;
    pulse(1'b1, 1'b0, 7'd61, 3);                                 // E'3
    chk("presc_rst", 16'h0000, 1'b1, 7'd61, S_ATT);
    cycle();                                                     // E'4
    chk("first_tick", 16'h4000, 1'b1, 7'd61, S_ATT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Monophonic ADSR envelope generator that sits directly downstream of the MIDI note interpreter. It consumes the interpreter's single-cycle `note_on`/`note_off` pulses and the 7-bit note number, and tracks the held note with last-note priority. It produces a 16-bit amplitude envelope that the oscillator/output stage multiplies against the waveform. Envelope steps advance on a prescaled tick so that rates are usable at audio time scales.

## Interface
- `ENV_W`, 16: envelope amplitude width; full scale MAX = 2^ENV_W − 1.
- `TICK_DIV`, 1024: clock cycles per envelope step; legal range ≥ 2.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `note_on`  in  1: single-cycle Note On pulse from the interpreter.
- `note_off`  in  1: single-cycle Note Off pulse from the interpreter.
- `note_in`  in  7: note number, valid in the same cycle as the `note_on`/`note_off` pulse.
- `attack_rate`  in  ENV_W: amount added per tick in ATTACK; 0 means instant.
- `decay_rate`  in  ENV_W: amount subtracted per tick in DECAY; 0 means instant.
- `sustain_level`  in  ENV_W: SUSTAIN target level.
- `release_rate`  in  ENV_W: amount subtracted per tick in RELEASE; 0 means instant.
- `env_out`  out  ENV_W: registered envelope amplitude.
- `gate`  out  1: registered; 1 while a key is held.
- `held_note`  out  7: note currently owning the envelope.
- `env_active`  out  1: registered; 1 when state ≠ IDLE.
- `state_out`  out  3: state encoding IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- **Reset values:** `env_out`=0, `gate`=0, `held_note`=0, `env_active`=0, `state_out`=IDLE, prescaler=0. Asserting reset mid-envelope forces all of these immediately.
- **Prescaler:** free-running from 0 to TICK_DIV−1, then wraps. `tick`=1 when count = TICK_DIV−1. Note events never reset the prescaler.
- **`note_on`, in any state:** latch `held_note` ← `note_in`, set `gate`=1, enter ATTACK. `env_out` is NOT cleared, so a retrigger is legato from the current level.
- **`note_off` with `note_in` = `held_note` and `gate`=1, in ATTACK/DECAY/SUSTAIN:** `gate`=0, enter RELEASE.
- **All other `note_off` cases are ignored:** non-matching note, IDLE, or RELEASE.
- **Simultaneous `note_on` and `note_off`:** `note_on` wins and `note_off` is dropped.
- **ATTACK, on tick:** compute sum = env + attack_rate at ENV_W+1 bits. If sum ≥ MAX or `attack_rate`=0, then env ← MAX and enter DECAY. Otherwise env ← sum.
- **DECAY, on tick:** if env ≤ sustain + decay_rate (widened compare) or `decay_rate`=0, then env ← sustain and enter SUSTAIN. Otherwise env ← env − decay_rate.
- **SUSTAIN, every cycle (not only on tick):** env ← `sustain_level`, so live edits to the sustain level are tracked.
- **RELEASE, on tick:** if env ≤ release_rate or `release_rate`=0, then env ← 0 and enter IDLE. Otherwise env ← env − release_rate.
- **IDLE:** env held at 0.
- **Arithmetic:** no wrap-around is allowed. All add/subtract operations saturate by the rules above. `sustain_level`=MAX makes DECAY exit on its first tick. `sustain_level`=0 makes SUSTAIN silent but still gated.

## Timing
- A note event in cycle N updates `gate`, `held_note`, `state_out` and `env_active` at edge N+1.
- `env_out` changes only at the edge after a tick cycle, except in SUSTAIN, where it follows `sustain_level` with 1-cycle latency.
- A state transition and its saturating env update happen on the same edge.
- The first envelope step after `note_on` occurs on the first tick at or after cycle N+1, which is at most TICK_DIV cycles later.
- `note_on` coinciding with a tick: the state change takes effect and the tick is not applied to the old state.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** drive `rst_n`=0 mid-ATTACK (with `env_out` ≠ 0) → all outputs return to their reset values asynchronously, without waiting for a clock edge.
- **Attack:** TICK_DIV=4, attack_rate=0x4000, `note_on` note 60 → `env_out` steps 0x4000, 0x8000, 0xC000, 0xFFFF on 4 consecutive ticks, then `state_out`=DECAY.
- **Decay:** decay_rate=0x1000, sustain=0x8000 → 7 steps down to 0x8FFF, then clamps to 0x8000 on the 8th tick and enters SUSTAIN. Changing sustain to 0x6000 → `env_out`=0x6000 one cycle later.
- **Release:** `note_off` note 60 in SUSTAIN (0x8000), release_rate=0x2000 → `gate`=0 next cycle; env goes 0x6000, 0x4000, 0x2000, 0, then IDLE with `env_active`=0.
- **Note filtering:**
  - Hold note 60, send `note_off` note 62 → no change.
  - Send `note_on` 64 during RELEASE at env 0x3000 → ATTACK resumes from 0x3000 with `held_note`=64.
  - Send `note_on` 65 and `note_off` 64 in the same cycle → ATTACK with `held_note`=65.
- **Zero rates:** attack=decay=release=0 → env jumps MAX→sustain→0 on successive ticks, with no wrap.
